inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
//  Instruction prefetch unit feeding the CPU IF stage. Fetches 16-bit instructions from
//  instruction memory over a req/ack handshake, buffers them with their PC in a small
//  queue, and presents the head entry to IF. On a taken branch/jump, IF redirects it,
//  which flushes the queue. Decouples pipeline fetch from a memory with variable wait states.
// PARAMETERS
//  DEPTH  4   queue entries (power of 2, >=2)
//  AW     8   instruction address / PC width
//  DW     16  instruction width
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  enable       in   1   1 = may start new memory requests; 0 = no new request starts
//  i_req        out  1   memory request, held until acked
//  i_addr       out  AW  request address, stable while i_req=1
//  i_ack        in   1   memory ack; i_datain valid in the same cycle
//  i_datain     in   DW  instruction word from memory
//  if_valid     out  1   head entry valid
//  if_instr     out  DW  head instruction; 16'h0000 (NOP) when empty
//  if_pc        out  AW  PC of head instruction; 0 when empty
//  if_ready     in   1   IF consumes head when if_valid & if_ready (pop)
//  redirect     in   1   flush and refetch from redirect_pc
//  redirect_pc  in   AW  new fetch PC
// BEHAVIOUR
//  Reset: fetch_pc=0, count=0, FSM=IDLE, i_req=0, i_addr=0, if_valid=0, if_instr=0, if_pc=0.
//  Handshake: once i_req=1, i_req and i_addr are held until a cycle with i_ack=1; at most one
//   request outstanding. Data is captured on the ack edge.
//  FSM states: IDLE (no request), REQ (request outstanding, data kept), DROP (request
//   outstanding, data discarded on ack).
//  Issue rule, evaluated every edge: next_count = count + push - pop; a new request is
//   registered (i_req=1, i_addr=fetch_pc) iff enable & !redirect & next_count < DEPTH and
//   no request remains outstanding after this edge. fetch_pc increments on each issue,
//   modulo 2^AW (8'hFF -> 8'h00).
//  IDLE -> REQ on issue. REQ + ack: push {i_addr,i_datain}; then REQ (back-to-back issue)
//   or IDLE. REQ + redirect without ack -> DROP. REQ + redirect with ack -> data discarded,
//   IDLE or REQ at redirect_pc per the issue rule (redirect blocks issue that edge, so IDLE).
//   DROP + ack -> IDLE, no push. Redirect in DROP: update fetch_pc, stay DROP.
//  Redirect: highest priority; count=0, pushes and pops that edge are ignored, fetch_pc=
//   redirect_pc; if_valid=0 the next cycle.
//  Latency: zero-wait memory (ack in the i_req cycle): first i_req in the cycle after reset
//   falls; if_valid 1 cycle after the ack. Sustained throughput is 1 instr/cycle.
//  Full: no request issued, so no overflow is possible. Empty: pop is ignored.
//   Simultaneous push+pop keeps count.
//  enable=0: an outstanding request still completes and pushes; pops continue.
//  Reset mid-request: i_req drops at the reset edge; any later ack is ignored (IDLE).
//  if_instr/if_pc: combinational read of the head register entry.
// STRUCTURE
//  Shared cpu_defs include/package: AW/DW widths, OP_NOP=5'b00000, NOP_WORD=16'h0000,
//   FSM state encodings PF_IDLE/PF_REQ/PF_DROP.
//  Sub-module pfq_fifo: synchronous FIFO (DEPTH x (AW+DW)) with push, pop, flush, count,
//   head outputs. The top holds the fetch FSM, fetch_pc and issue logic.
// TESTING
//  1 Zero-wait memory, mem[k]=16'h1000+k, if_ready=1: i_addr 0,1,2,..., one per cycle;
//    if_pc/if_instr 0/1000, 1/1001 on consecutive cycles.
//  2 if_ready=0, ack always 1: exactly 4 entries pushed, i_req stays 0 and if_valid=1;
//    one pop -> exactly one new request.
//  3 Ack delayed 3 cycles: i_req and i_addr=8'h05 stable for 3 cycles; entry pc 05 appears
//    after the ack.
//  4 Redirect to 8'h40 while request to 8'h07 is outstanding: state DROP, ack data dropped,
//    next i_addr=8'h40, first if_pc=8'h40, and no 07 entry appears.
//  5 fetch_pc=8'hFE, run 3 fetches: i_addr FE, FF, 00.
//  6 Reset asserted with 2 entries queued and a request pending: the next cycle
//    if_valid=0, i_req=0, if_instr=0000; the late ack is ignored.

Source files
------------

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   PFQ_DEPTH/PFQ_AW/PFQ_DW : default queue depth, PC width, instruction width
//   NOP_WORD                : instruction presented to IF while the queue is empty
//   PF_IDLE/PF_REQ/PF_DROP  : fetch FSM encodings
package inst_prefetch_queue_pkg;

    localparam int PFQ_DEPTH = 4;
    localparam int PFQ_AW    = 8;
    localparam int PFQ_DW    = 16;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef logic [1:0] pf_state_t;

    localparam pf_state_t PF_IDLE = 2'd0;  // no request outstanding
    localparam pf_state_t PF_REQ  = 2'd1;  // request outstanding, data will be queued
    localparam pf_state_t PF_DROP = 2'd2;  // request outstanding, data discarded on ack

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Handshake bundle of the prefetch queue.
//   memory side : i_req/i_addr out, i_ack/i_datain in
//   IF side     : if_valid/if_instr/if_pc out, if_ready in, redirect/redirect_pc in
// master = prefetch unit, slave = memory + IF stage.
interface inst_prefetch_queue_if
    import inst_prefetch_queue_pkg::*;
#(
    parameter int AW = PFQ_AW,
    parameter int DW = PFQ_DW
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_datain;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;

    modport master (
        output i_req, i_addr, if_valid, if_instr, if_pc,
        input  i_ack, i_datain, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  i_req, i_addr, if_valid, if_instr, if_pc,
        output i_ack, i_datain, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// pfq_fifo: synchronous FIFO of DEPTH entries, W bits each.
//   clk_i, rst_i (sync, active-high), flush_i (sync clear)
//   push_i/din_i : write (ignored when full or flushing)
//   pop_i        : read advance (ignored when empty or flushing)
//   head_o       : oldest entry (combinational), count_o, empty_o
module pfq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & (cnt_q != (PW+1)'(DEPTH)) & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through the counter.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch unit: fetches instructions over a req/ack handshake,
// queues {pc, instr} and presents the head entry to IF. A redirect flushes the
// queue and restarts fetching at redirect_pc.
//   clk_i, rst_i : clock, synchronous active-high reset
//   enable_i     : permits starting new memory requests
//   bus          : memory and IF handshakes (master side)
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PFQ_DEPTH,
    parameter int AW    = PFQ_AW,
    parameter int DW    = PFQ_DW
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    inst_prefetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_t     state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] count, next_count;
    logic [AW+DW-1:0] head;
    logic          empty, push, pop, issue, still_out;

    // A redirect cancels any push or pop on the same edge.
    assign push = (state_q == PF_REQ) & bus.i_ack & ~bus.redirect;
    assign pop  = ~empty & bus.if_ready & ~bus.redirect;

    assign next_count = bus.redirect ? '0 : count + CW'(push) - CW'(pop);

    // Request still pending after this edge: at most one may be outstanding.
    assign still_out = ((state_q == PF_REQ) || (state_q == PF_DROP)) & ~bus.i_ack;

    // Space is judged on the post-edge count, so a full queue never issues.
    assign issue = enable_i & ~bus.redirect & (next_count < CW'(DEPTH)) & ~still_out;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;

        if (still_out)
            state_d = ((state_q == PF_REQ) && bus.redirect) ? PF_DROP : state_q;
        else
            state_d = issue ? PF_REQ : PF_IDLE;

        if (bus.redirect)
            fetch_pc_d = bus.redirect_pc;
        else if (issue)
            fetch_pc_d = fetch_pc_q + AW'(1);

        if (issue) addr_d = fetch_pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    // i_req comes straight from the state register, so it is held until ack.
    assign bus.i_req  = (state_q == PF_REQ) || (state_q == PF_DROP);
    assign bus.i_addr = addr_q;

    pfq_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.redirect),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({addr_q, bus.i_datain}),
        .head_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign bus.if_valid = ~empty;
    assign bus.if_instr = empty ? DW'(NOP_WORD) : head[DW-1:0];
    assign bus.if_pc    = empty ? '0 : head[AW+DW-1:DW];
endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;
    logic clk = 1'b0;
    logic rst, enable;
    int   ack_mode;   // 0: zero-wait (ack = i_req), 1: manual, 2: ack always high
    logic ack_man;

    always #5 clk = ~clk;

    inst_prefetch_queue_if bus ();

    assign bus.i_ack    = (ack_mode == 0) ? bus.i_req : (ack_mode == 1) ? ack_man : 1'b1;
    assign bus.i_datain = 16'h1000 + {8'h00, bus.i_addr};

    inst_prefetch_queue dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_acc = 0;
    int acc0;
    logic [7:0]  exp_addr_q [$];
    logic [23:0] exp_if_q [$];
    logic [7:0]  ea;
    logic [23:0] ei;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic exp_fetch(input logic [7:0] pc);
        exp_addr_q.push_back(pc);
        exp_if_q.push_back({pc, 16'h1000 + {8'h00, pc}});
    endtask

    // Monitor: every accepted request and every consumed head entry is
    // compared against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.i_req && bus.i_ack) begin
                n_acc++;
                if (exp_addr_q.size() == 0) chk("req_unexpected", exp_addr_q.size(), 1);
                else begin
                    ea = exp_addr_q.pop_front();
                    chk("i_addr", {24'h0, bus.i_addr}, {24'h0, ea});
                end
            end
            if (bus.if_valid && bus.if_ready && !bus.redirect) begin
                if (exp_if_q.size() == 0) chk("pop_unexpected", exp_if_q.size(), 1);
                else begin
                    ei = exp_if_q.pop_front();
                    chk("if_pc_instr", {8'h0, bus.if_pc, bus.if_instr}, {8'h0, ei});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; ack_mode = 0; ack_man = 1'b0;
        bus.if_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_i_req",    bus.i_req,    0);
        chk("rst_i_addr",   bus.i_addr,   0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_instr", bus.if_instr, 0);
        chk("rst_if_pc",    bus.if_pc,    0);

        // 1: zero-wait streaming, addresses 0..7
        for (int k = 0; k < 8; k++) exp_fetch(8'(k));
        rst = 1'b0; enable = 1'b1; bus.if_ready = 1'b1;
        @(negedge clk);
        chk("t1_first_req",  bus.i_req,    1);
        chk("t1_first_addr", bus.i_addr,   0);
        chk("t1_latency",    bus.if_valid, 0);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            chk("t1_stream_valid", bus.if_valid, 1);
            if (k == 8) enable = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("t1_drained", bus.if_valid, 0);
        chk("t1_idle",    bus.i_req,    0);

        // 2: IF stalled, queue fills to exactly DEPTH
        for (int k = 8; k < 12; k++) exp_fetch(8'(k));
        bus.if_ready = 1'b0; ack_mode = 2; enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("t2_full_no_req", bus.i_req,    0);
        chk("t2_full_valid",  bus.if_valid, 1);
        chk("t2_full_head",   bus.if_pc,    8'h08);
        acc0 = n_acc;
        @(posedge clk); #1;
        bus.if_ready = 1'b1;
        exp_fetch(8'h0C);
        @(posedge clk); #1;
        bus.if_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("t2_one_refill", n_acc - acc0, 1);
        chk("t2_refull_req", bus.i_req,    0);
        chk("t2_head_after", bus.if_pc,    8'h09);
        @(posedge clk); #1;
        enable = 1'b0; bus.if_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t2_drained", bus.if_valid, 0);

        // 3: ack delayed, request held stable
        @(posedge clk); #1;
        ack_mode = 1; ack_man = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 8'h05;
        @(posedge clk); #1;
        bus.redirect = 1'b0; enable = 1'b1;
        exp_fetch(8'h05);
        @(posedge clk); #1;
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_req_held",  bus.i_req,  1);
            chk("t3_addr_held", bus.i_addr, 8'h05);
        end
        @(posedge clk); #1;
        ack_man = 1'b1;
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk("t3_req_done", bus.i_req, 0);
        chk("t3_entry_pc", bus.if_pc, 8'h05);
        repeat (2) @(negedge clk);

        // 4: redirect while request to 07 is outstanding
        @(posedge clk); #1;
        bus.redirect = 1'b1; bus.redirect_pc = 8'h07;
        @(posedge clk); #1;
        bus.redirect = 1'b0; enable = 1'b1;
        exp_addr_q.push_back(8'h07);
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        chk("t4_req07", bus.i_addr, 8'h07);
        @(posedge clk); #1;
        bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("t4_drop_req_held", bus.i_req,  1);
        chk("t4_drop_addr",     bus.i_addr, 8'h07);
        @(posedge clk); #1;
        ack_man = 1'b1;
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk("t4_dropped_no_entry", bus.if_valid, 0);
        chk("t4_dropped_idle",     bus.i_req,    0);
        @(posedge clk); #1;
        enable = 1'b1;
        exp_fetch(8'h40);
        @(posedge clk); #1;
        enable = 1'b0;
        @(negedge clk);
        chk("t4_new_addr", bus.i_addr, 8'h40);
        @(posedge clk); #1;
        ack_man = 1'b1;
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk("t4_first_pc", bus.if_pc, 8'h40);
        repeat (2) @(negedge clk);

        // 5: fetch_pc wraps FE, FF, 00
        @(posedge clk); #1;
        ack_mode = 0; bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
        @(posedge clk); #1;
        bus.redirect = 1'b0; enable = 1'b1;
        exp_fetch(8'hFE); exp_fetch(8'hFF); exp_fetch(8'h00);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_drained", bus.if_valid, 0);

        // 6: reset with two entries queued and request 03 pending
        @(posedge clk); #1;
        bus.if_ready = 1'b0; enable = 1'b1;
        exp_addr_q.push_back(8'h01); exp_addr_q.push_back(8'h02);
        repeat (3) @(posedge clk);
        #1 ack_mode = 1; ack_man = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("t6_pending_req", bus.i_addr, 8'h03);
        chk("t6_head_pc",     bus.if_pc,  8'h01);
        chk("t6_head_instr",  bus.if_instr, 16'h1001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ack_man = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", bus.if_valid, 0);
        chk("t6_rst_req",   bus.i_req,    0);
        chk("t6_rst_instr", bus.if_instr, 0);
        chk("t6_rst_pc",    bus.if_pc,    0);
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk("t6_late_ack_valid", bus.if_valid, 0);
        chk("t6_late_ack_req",   bus.i_req,    0);

        chk("sb_addr_empty", exp_addr_q.size(), 0);
        chk("sb_if_empty",   exp_if_q.size(),   0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
